// File: rtl/sar_pkg.sv
// ----------------------------------------------------------------------------
// sar_pkg : shared SAR ADC types and default parameters
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package sar_pkg;

  localparam int SAR_N             = 4;
  localparam int SAR_SAMPLE_CYCLES = 2;
  localparam int SAR_SETTLE_CYCLES = 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SAMPLE = 2'd1,
    S_CONV   = 2'd2,
    S_DONE   = 2'd3
  } sar_state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sar_phase_timer.sv
// ----------------------------------------------------------------------------
// sar_phase_timer : loadable saturating down-counter with terminal-count flag
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sar_phase_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign tc = (count == '0);

endmodule

`default_nettype wire

// File: rtl/sar4_logic.sv
// ----------------------------------------------------------------------------
// sar4_logic : SAR ADC control - request edge detect, sample, MSB-first search
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sar4_logic
  import sar_pkg::*;
#(
  parameter int N             = SAR_N,
  parameter int SAMPLE_CYCLES = SAR_SAMPLE_CYCLES,
  parameter int SETTLE_CYCLES = SAR_SETTLE_CYCLES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         comp,
  output logic         sample,
  output logic [N-1:0] dac_code,
  output logic [N-1:0] result,
  output logic         done,
  output logic         busy
);

  localparam int CW = $clog2(max2(SAMPLE_CYCLES, SETTLE_CYCLES) + 1);
  localparam int KW = $clog2(N);
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] MSB = {1'b1, {(N-1){1'b0}}};
  localparam logic [CW-1:0] SAMPLE_LOAD = CW'(SAMPLE_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);

  sar_state_t    state;
  logic          start_q;
  logic          start_rise;
  logic [KW-1:0] bit_idx;
  logic [N-1:0]  decided;
  logic [N-1:0]  next_bit;
  logic          timer_load;
  logic [CW-1:0] timer_val;
  logic          tc;
  logic          can_start;

  assign start_rise = start & ~start_q;
  assign can_start  = (state == S_IDLE) || (state == S_DONE);

  // One timer serves both phases: reload on a request, at end of sampling,
  // and at the end of every bit trial.
  assign timer_load = (can_start && start_rise) ||
                      (tc && ((state == S_SAMPLE) || (state == S_CONV)));
  assign timer_val  = can_start ? SAMPLE_LOAD : SETTLE_LOAD;

  sar_phase_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (timer_val),
    .tc       (tc)
  );

  always_comb begin
    decided          = dac_code;
    decided[bit_idx] = comp;
  end

  assign next_bit = ONE << (bit_idx - 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      start_q  <= 1'b0;
      sample   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      dac_code <= '0;
      result   <= '0;
      bit_idx  <= '0;
    end else begin
      start_q <= start;
      done    <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start_rise) begin
            state    <= S_SAMPLE;
            sample   <= 1'b1;
            busy     <= 1'b1;
            dac_code <= '0;
          end else begin
            state <= S_IDLE;
          end
        end
        S_SAMPLE: begin
          if (tc) begin
            state    <= S_CONV;
            sample   <= 1'b0;
            dac_code <= MSB;
            bit_idx  <= KW'(N - 1);
          end
        end
        S_CONV: begin
          if (tc) begin
            if (bit_idx != '0) begin
              dac_code <= decided | next_bit;
              bit_idx  <= bit_idx - 1'b1;
            end else begin
              dac_code <= decided;
              result   <= decided;
              done     <= 1'b1;
              busy     <= 1'b0;
              state    <= S_DONE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/sar4_logic.md
# sar4_logic

Successive-approximation control logic for the N-bit (default 4) SAR ADC. It sits directly downstream of the start/comparator stimulus and the comparator. It detects a conversion request, drives the sample switch, and steps the DAC trial code MSB-first from the comparator decisions. It then publishes the final code with a one-cycle done pulse.

## Interface
- N, 4: conversion resolution in bits (≥2).
- SAMPLE_CYCLES, 2: clock cycles the `sample` switch is held closed (≥1).
- SETTLE_CYCLES, 1: cycles per bit trial; `comp` is sampled on the last edge of the trial (≥1).

Ports:
- clk  in  1  single system clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  conversion request, level input; only a 0→1 transition is a request.
- comp  in  1  comparator decision. 1 means Vin ≥ Vdac (keep bit); 0 means clear bit.
- sample  out  1  track/hold switch control, high during SAMPLE.
- dac_code  out  N  trial code driving the capacitive DAC.
- result  out  N  last completed conversion code.
- done  out  1  one-cycle pulse; `result` is valid from this cycle.
- busy  out  1  high in SAMPLE and CONV.

## Operation
- Edge detect: `start_q` is registered every cycle. `start_rise = start & ~start_q`.
- States: IDLE, SAMPLE, CONV, DONE.
- IDLE:
  - `start_rise` → SAMPLE.
  - Load sample counter with SAMPLE_CYCLES−1.
  - `dac_code` ← 0.
- SAMPLE:
  - `sample`=1.
  - When the counter reaches 0 → CONV, with bit index k=N−1 and `dac_code` ← 1<<(N−1).
- CONV:
  - The settle counter runs SETTLE_CYCLES cycles per bit.
  - On the last edge of a trial, bit k of `dac_code` is kept if `comp`=1 and cleared if 0.
  - If k>0, bit k−1 is set and k decrements.
  - If k=0, go to DONE; `result` ← the decided code.
- DONE:
  - `done`=1 for exactly one cycle, then go to IDLE.
  - A `start_rise` seen in DONE goes directly to SAMPLE.
- `start_rise` while `busy`=1 is ignored and is not queued.
- A `start` held high does not retrigger.
- `comp` is sampled only on decision edges and is ignored otherwise. There is no internal synchronizer: the comparator is latched by the same clock.
- `dac_code` keeps the final code in DONE/IDLE until the next SAMPLE clears it. `result` holds until the next DONE.
- Counters are width $clog2(max(SAMPLE_CYCLES,SETTLE_CYCLES)+1). The bit index is $clog2(N) wide and never wraps below 0.

## Timing
- Reset values (asynchronous, immediate on `rst_n`=0):
  - `sample`, `dac_code`, `result`, `done`, `busy` = 0.
  - state = IDLE; `start_q` = 0.
- Cycle numbering: E0 is the edge where `start_rise` is seen in IDLE or DONE.
  - `sample`/`busy` rise after E0.
  - `sample` falls after E(SAMPLE_CYCLES); the first trial code appears at the same edge.
- Decision edges: E(SAMPLE_CYCLES + j·SETTLE_CYCLES), for j=1..N.
- `done` is high in the cycle after E(SAMPLE_CYCLES + N·SETTLE_CYCLES). Defaults give done high E6→E7.
- Total latency: SAMPLE_CYCLES + N·SETTLE_CYCLES cycles from E0 to `done`.
- Reset mid-operation aborts the conversion: no `done`, `result` cleared. After release the block sits in IDLE; `start_q`=0, so a `start` already high counts as a rise on the first edge.

## Structure
- Shared package `sar_pkg`: state enum (IDLE, SAMPLE, CONV, DONE) and default N/SAMPLE_CYCLES/SETTLE_CYCLES constants, also used by the stimulus and DAC blocks.
- One sub-module, `sar_phase_timer`: a loadable down-counter with a terminal-count flag, reused for the SAMPLE and settle phases.
- Edge detect, FSM and code register live in `sar4_logic`.

## Test plan
- Reset: `rst_n`=0 with random inputs → all outputs 0. Release with `start`=0 → IDLE, `busy`=0.
- Model comp=(vin≥dac_code), vin=4'b1010, defaults:
  - `dac_code` sequence 1000, 1100, 1010, 1011.
  - `result`=1010; `done` high only E6→E7.
- Extremes: vin=0 → `result`=0000; vin=15 → `result`=1111. Both with `done` exactly 6 cycles after E0.
- Request filtering:
  - `start` held high after `done` → no second conversion.
  - `start` toggled during CONV → ignored, result unchanged.
  - `start` rise during DONE → `sample` rises next cycle.
- Abort: `rst_n` pulsed low at E4 of a vin=10 conversion → outputs 0 immediately. No `done` follows; the next request gives `result`=1010.
- Parameters N=4, SAMPLE_CYCLES=1, SETTLE_CYCLES=3, vin=5:
  - Decision edges at E4, E7, E10, E13.
  - `result`=0101; `done` after E13.
